tx: RTL and testbench

- PICC-to-PCD transmitter for the ISO/IEC 14443A PICC.
- Takes bytes or partial bytes from the frame-building logic over a valid/ready handshake.
- Produces a standard frame: SOC, LSB-first data, odd parity after each full byte, then EOC.
- Outputs the frame as Manchester-coded symbols on an fc/16 subcarrier, on the load-modulator drive lm_out.

---
 rtl/tx_pkg.sv | 32 +++
 rtl/tx_sequence_encode.sv | 55 +++++
 rtl/tx.sv | 182 ++++++++++++++++++
 tb/tb_tx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// ISO14443A PICC transmit definitions: bit sequences, timing, FSM states.
// Shared by sequence_encode and tx.
package tx_pkg;

  typedef enum logic [1:0] {
    PICCBitSequence_D,
    PICCBitSequence_E,
    PICCBitSequence_F
  } PICCBitSequence;

  localparam int SYMBOL_CLKS          = 128;
  localparam int HALF_CLKS            = 64;
  localparam int SUBCARRIER_HALF_CLKS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOC,
    ST_DATA,
    ST_PARITY,
    ST_EOC
  } tx_state_e;

  function automatic PICCBitSequence bit_seq(input logic b);
    return b ? PICCBitSequence_D : PICCBitSequence_E;
  endfunction

  // Index of the final bit of an entry; 0 encodes a full byte.
  function automatic logic [2:0] last_idx(input logic [2:0] bits);
    return (bits == 3'd0) ? 3'd7 : bits - 3'd1;
  endfunction

endpackage

// File: rtl/tx_sequence_encode.sv
// Manchester/subcarrier symbol encoder: seq, seq_valid in; lm_out and
// seq_req (last clk of each symbol) out.
module sequence_encode
  import tx_pkg::*;
#(
  parameter bit INVERT_LM = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  PICCBitSequence seq,
  input  logic           seq_valid,
  output logic           lm_out,
  output logic           seq_req
);

  localparam int SC_BIT = $clog2(SUBCARRIER_HALF_CLKS);

  logic           active;
  PICCBitSequence seq_r;
  logic [6:0]     cnt;
  logic           second_half;
  logic           mod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      seq_r  <= PICCBitSequence_F;
      cnt    <= '0;
    end else if (seq_valid) begin
      active <= 1'b1;
      seq_r  <= seq;
      cnt    <= '0;
    end else if (active) begin
      active <= !seq_req;
      cnt    <= cnt + 7'd1;
    end
  end

  assign seq_req     = active && (cnt == 7'(SYMBOL_CLKS - 1));
  assign second_half = cnt >= 7'(HALF_CLKS);

  always_comb begin
    mod = 1'b0;
    unique case (seq_r)
      PICCBitSequence_D: mod = !second_half;
      PICCBitSequence_E: mod = second_half;
      default:           mod = 1'b0;
    endcase
  end

  // HALF_CLKS is a multiple of the subcarrier period, so the
  // subcarrier restarts at the start of each modulated half.
  assign lm_out = (active && mod && !cnt[SC_BIT]) ^ INVERT_LM;

endmodule

// File: rtl/tx.sv
// ISO14443A PICC-to-PCD frame transmitter: in_* valid/ready entries in,
// lm_out load-modulator drive, busy/done/underrun status out.
module tx
  import tx_pkg::*;
#(
  parameter bit INVERT_LM = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic [2:0] in_bits,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       lm_out,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  tx_state_e      state, state_nx;
  PICCBitSequence seq;
  logic           seq_valid, seq_req;

  logic [7:0] shift_q, byte_q;
  logic [2:0] idx_q, last_q;
  logic       full_q, end_q;

  logic [7:0] hold_data;
  logic [2:0] hold_bits;
  logic       hold_end, hold_vld, end_seen;

  logic       accept, in_end;
  logic       nxt_vld, nxt_end;
  logic [7:0] nxt_data;
  logic [2:0] nxt_bits;

  logic load_in, reload, shift_en;
  logic set_under, set_done;

  assign accept = in_valid && in_ready;
  assign in_end = in_last || (in_bits != 3'd0);
  assign busy   = state != ST_IDLE;

  // An entry arriving on the reload cycle bypasses the hold register.
  assign nxt_vld  = hold_vld || accept;
  assign nxt_data = hold_vld ? hold_data : in_data;
  assign nxt_bits = hold_vld ? hold_bits : in_bits;
  assign nxt_end  = hold_vld ? hold_end : in_end;

  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_EOC:  in_ready = 1'b0;
      default: in_ready = !hold_vld && !end_seen;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    seq       = PICCBitSequence_F;
    seq_valid = 1'b0;
    load_in   = 1'b0;
    reload    = 1'b0;
    shift_en  = 1'b0;
    set_under = 1'b0;
    set_done  = 1'b0;
    unique case (state)
      ST_IDLE: if (accept) begin
        state_nx  = ST_SOC;
        seq       = PICCBitSequence_D;
        seq_valid = 1'b1;
        load_in   = 1'b1;
      end
      ST_SOC: if (seq_req) begin
        state_nx  = ST_DATA;
        seq       = bit_seq(shift_q[0]);
        seq_valid = 1'b1;
      end
      ST_DATA: if (seq_req) begin
        seq_valid = 1'b1;
        if (idx_q != last_q) begin
          seq      = bit_seq(shift_q[1]);
          shift_en = 1'b1;
        end else if (full_q) begin
          state_nx = ST_PARITY;
          seq      = bit_seq(~^byte_q);
        end else begin
          state_nx = ST_EOC;
        end
      end
      ST_PARITY: if (seq_req) begin
        seq_valid = 1'b1;
        if (end_q) begin
          state_nx = ST_EOC;
        end else if (nxt_vld) begin
          state_nx = ST_DATA;
          seq      = bit_seq(nxt_data[0]);
          reload   = 1'b1;
        end else begin
          state_nx  = ST_EOC;
          set_under = 1'b1;
        end
      end
      ST_EOC: if (seq_req) begin
        state_nx = ST_IDLE;
        set_done = 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      byte_q    <= '0;
      idx_q     <= '0;
      last_q    <= '0;
      full_q    <= 1'b0;
      end_q     <= 1'b0;
      hold_data <= '0;
      hold_bits <= '0;
      hold_end  <= 1'b0;
      hold_vld  <= 1'b0;
      end_seen  <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      done     <= set_done;
      underrun <= set_under;

      if (load_in) begin
        shift_q <= in_data;
        byte_q  <= in_data;
        idx_q   <= '0;
        last_q  <= last_idx(in_bits);
        full_q  <= in_bits == 3'd0;
        end_q   <= in_end;
      end else if (reload) begin
        shift_q <= nxt_data;
        byte_q  <= nxt_data;
        idx_q   <= '0;
        last_q  <= last_idx(nxt_bits);
        full_q  <= nxt_bits == 3'd0;
        end_q   <= nxt_end;
      end else if (shift_en) begin
        shift_q <= shift_q >> 1;
        idx_q   <= idx_q + 3'd1;
      end

      if (reload) begin
        hold_vld <= 1'b0;
      end else if (accept && state != ST_IDLE) begin
        hold_vld  <= 1'b1;
        hold_data <= in_data;
        hold_bits <= in_bits;
        hold_end  <= in_end;
      end

      if (state == ST_IDLE)      end_seen <= accept && in_end;
      else if (accept && in_end) end_seen <= 1'b1;
    end
  end

  sequence_encode #(
    .INVERT_LM(INVERT_LM)
  ) u_enc (
    .clk      (clk),
    .rst_n    (rst_n),
    .seq      (seq),
    .seq_valid(seq_valid),
    .lm_out   (lm_out),
    .seq_req  (seq_req)
  );

endmodule

// File: tb/tb_tx.sv
// Directed testbench for tx: frame shapes, buffering, underrun, reset.
// Prints one TB_RESULT summary line.
`timescale 1ns/1ps
module tb_tx;

  localparam int SD = 0;
  localparam int SE = 1;
  localparam int SF = 2;
  localparam int NMAX = 2600;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic [2:0] in_bits = '0;
  logic       in_last = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready, lm_out, busy, done, underrun;

  int checks = 0;
  int failures = 0;

  logic lm_a [1:NMAX];
  logic bz_a [1:NMAX];
  logic dn_a [1:NMAX];
  logic ur_a [1:NMAX];
  logic rd_a [1:NMAX];

  tx #(.INVERT_LM(1'b0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_data (in_data),
    .in_bits (in_bits),
    .in_last (in_last),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .lm_out  (lm_out),
    .busy    (busy),
    .done    (done),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] sym_pat(input int s);
    logic [127:0] p;
    p = '0;
    for (int i = 0; i < 128; i++)
      p[i] = ((s == SD && i < 64) || (s == SE && i >= 64))
             && ((i % 16) < 8);
    return p;
  endfunction

  task automatic send(input logic [7:0] d, input logic [2:0] b,
                      input logic l);
    @(negedge clk);
    in_data  = d;
    in_bits  = b;
    in_last  = l;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Records outputs at cycles t+1..t+n; optionally presents an entry
  // during cycle t+inj_k.
  task automatic capture(input int n, input int inj_k,
                         input logic [7:0] d, input logic [2:0] b,
                         input logic l);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      lm_a[k] = lm_out;
      bz_a[k] = busy;
      dn_a[k] = done;
      ur_a[k] = underrun;
      rd_a[k] = in_ready;
      if (k == inj_k) begin
        in_data  = d;
        in_bits  = b;
        in_last  = l;
        in_valid = 1'b1;
      end else if (k == inj_k + 1) begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (lm_out !== 1'b0) begin
      failures++; $display("FAIL reset_lm got=%b exp=0", lm_out);
    end
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b exp=1", in_ready);
    end
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    if (done !== 1'b0) begin
      failures++; $display("FAIL reset_done got=%b exp=0", done);
    end
    if (underrun !== 1'b0) begin
      failures++; $display("FAIL reset_underrun got=%b exp=0", underrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_one_byte;
    int syms[$];
    logic [127:0] act, exp;
    int early, bad_busy, ur_cnt;
    syms = '{SD, SD, SE, SE, SE, SE, SE, SE, SE, SE, SF};
    send(8'h01, 3'd0, 1'b1);
    capture(1409, 0, 8'h00, 3'd0, 1'b0);
    foreach (syms[j]) begin
      for (int i = 0; i < 128; i++) act[i] = lm_a[1 + 128 * j + i];
      exp = sym_pat(syms[j]);
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL one_byte_sym%0d got=%h exp=%h", j, act, exp);
      end
    end
    early = 0; bad_busy = 0; ur_cnt = 0;
    for (int k = 1; k <= 1408; k++) begin
      if (dn_a[k] !== 1'b0) early++;
      if (bz_a[k] !== 1'b1) bad_busy++;
      if (ur_a[k] !== 1'b0) ur_cnt++;
    end
    checks += 6;
    if (early != 0) begin
      failures++; $display("FAIL one_byte_early_done got=%0d exp=0", early);
    end
    if (bad_busy != 0) begin
      failures++; $display("FAIL one_byte_busy got=%0d exp=0", bad_busy);
    end
    if (ur_cnt != 0) begin
      failures++; $display("FAIL one_byte_underrun got=%0d exp=0", ur_cnt);
    end
    if (dn_a[1409] !== 1'b1) begin
      failures++; $display("FAIL one_byte_done got=%b exp=1", dn_a[1409]);
    end
    if (bz_a[1409] !== 1'b0) begin
      failures++; $display("FAIL one_byte_idle_busy got=%b exp=0", bz_a[1409]);
    end
    if (rd_a[64] !== 1'b0) begin
      failures++; $display("FAIL one_byte_ready got=%b exp=0", rd_a[64]);
    end
  endtask

  task automatic test_back_to_back;
    int syms[$];
    logic [127:0] act, exp;
    int rd_bad, early;
    syms = '{SD,
             SE, SE, SD, SE, SE, SE, SD, SE, SD,
             SE, SE, SE, SE, SE, SE, SE, SE, SD,
             SF};
    send(8'h44, 3'd0, 1'b0);
    capture(2561, 1000, 8'h00, 3'd0, 1'b1);
    foreach (syms[j]) begin
      for (int i = 0; i < 128; i++) act[i] = lm_a[1 + 128 * j + i];
      exp = sym_pat(syms[j]);
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL atqa_sym%0d got=%h exp=%h", j, act, exp);
      end
    end
    rd_bad = 0; early = 0;
    for (int k = 1001; k <= 2560; k++) if (rd_a[k] !== 1'b0) rd_bad++;
    for (int k = 1; k <= 2560; k++) if (dn_a[k] !== 1'b0) early++;
    checks += 5;
    if (rd_a[1000] !== 1'b1) begin
      failures++; $display("FAIL atqa_ready_open got=%b exp=1", rd_a[1000]);
    end
    if (rd_bad != 0) begin
      failures++; $display("FAIL atqa_ready_closed got=%0d exp=0", rd_bad);
    end
    if (early != 0) begin
      failures++; $display("FAIL atqa_early_done got=%0d exp=0", early);
    end
    if (dn_a[2561] !== 1'b1) begin
      failures++; $display("FAIL atqa_done got=%b exp=1", dn_a[2561]);
    end
    if (rd_a[2561] !== 1'b1) begin
      failures++; $display("FAIL atqa_idle_ready got=%b exp=1", rd_a[2561]);
    end
  endtask

  task automatic test_partial;
    int syms[$];
    logic [127:0] act, exp;
    int early;
    syms = '{SD, SE, SD, SE, SD, SF};
    send(8'h0A, 3'd4, 1'b1);
    capture(769, 0, 8'h00, 3'd0, 1'b0);
    foreach (syms[j]) begin
      for (int i = 0; i < 128; i++) act[i] = lm_a[1 + 128 * j + i];
      exp = sym_pat(syms[j]);
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL partial_sym%0d got=%h exp=%h", j, act, exp);
      end
    end
    early = 0;
    for (int k = 1; k <= 768; k++) if (dn_a[k] !== 1'b0) early++;
    checks += 2;
    if (early != 0) begin
      failures++; $display("FAIL partial_early_done got=%0d exp=0", early);
    end
    if (dn_a[769] !== 1'b1) begin
      failures++; $display("FAIL partial_done got=%b exp=1", dn_a[769]);
    end
  endtask

  task automatic test_underrun;
    int syms[$];
    logic [127:0] act, exp;
    int ur_bad;
    syms = '{SD, SD, SD, SD, SD, SD, SD, SD, SD, SD, SF};
    send(8'hFF, 3'd0, 1'b0);
    capture(1409, 0, 8'h00, 3'd0, 1'b0);
    foreach (syms[j]) begin
      for (int i = 0; i < 128; i++) act[i] = lm_a[1 + 128 * j + i];
      exp = sym_pat(syms[j]);
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL underrun_sym%0d got=%h exp=%h", j, act, exp);
      end
    end
    ur_bad = 0;
    for (int k = 1; k <= 1409; k++)
      if (k != 1281 && ur_a[k] !== 1'b0) ur_bad++;
    checks += 4;
    if (ur_a[1281] !== 1'b1) begin
      failures++; $display("FAIL underrun_pulse got=%b exp=1", ur_a[1281]);
    end
    if (ur_bad != 0) begin
      failures++; $display("FAIL underrun_extra got=%0d exp=0", ur_bad);
    end
    if (rd_a[500] !== 1'b1) begin
      failures++; $display("FAIL underrun_ready got=%b exp=1", rd_a[500]);
    end
    if (dn_a[1409] !== 1'b1) begin
      failures++; $display("FAIL underrun_done got=%b exp=1", dn_a[1409]);
    end
  endtask

  task automatic test_reset_mid_soc;
    send(8'h01, 3'd0, 1'b1);
    capture(5, 0, 8'h00, 3'd0, 1'b0);
    checks++;
    if (lm_a[5] !== 1'b1) begin
      failures++; $display("FAIL midsoc_lm_before got=%b exp=1", lm_a[5]);
    end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (lm_out !== 1'b0) begin
      failures++; $display("FAIL midsoc_lm got=%b exp=0", lm_out);
    end
    if (busy !== 1'b0) begin
      failures++; $display("FAIL midsoc_busy got=%b exp=0", busy);
    end
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL midsoc_ready got=%b exp=1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_one_byte();
  endtask

  initial begin
    test_reset();
    test_one_byte();
    test_back_to_back();
    test_partial();
    test_underrun();
    test_reset_mid_soc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
